// File: rtl/frame_pair_aligner.sv
// frame_pair_aligner: locks prev/curr pixel streams on a shared SOF and emits them as one paired AXI-Stream
module frame_pair_aligner #(
   parameter int DATA_WIDTH = 32,
   parameter int H_RES      = 1920,
   parameter int V_RES      = 1080
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_prev_axis_tdata,
   input  logic                  s_prev_axis_tvalid,
   output logic                  s_prev_axis_tready,
   input  logic                  s_prev_axis_tlast,
   input  logic                  s_prev_axis_tuser,
   input  logic [DATA_WIDTH-1:0] s_curr_axis_tdata,
   input  logic                  s_curr_axis_tvalid,
   output logic                  s_curr_axis_tready,
   input  logic                  s_curr_axis_tlast,
   input  logic                  s_curr_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_prev_axis_tdata,
   output logic [DATA_WIDTH-1:0] m_curr_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic                  locked,
   output logic [15:0]           frame_cnt,
   output logic [15:0]           err_cnt
);
   localparam int XW = H_RES > 1 ? $clog2(H_RES) : 1;
   localparam int YW = V_RES > 1 ? $clog2(V_RES) : 1;
   localparam logic [0:0] WAIT_SOF = 1'b0;
   localparam logic [0:0] RUN      = 1'b1;
   logic [0:0]    state;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          run;
   logic          slot_free;
   logic          both_valid;
   logic          both_sof;
   logic          sof;
   logic          eol;
   logic          last_pix;
   logic          check_ok;
   logic          fire;
   logic          bad;
   assign run        = state == RUN;
   assign slot_free  = !m_axis_tvalid || m_axis_tready;
   assign both_valid = s_prev_axis_tvalid && s_curr_axis_tvalid;
   assign both_sof   = !run && both_valid && s_prev_axis_tuser && s_curr_axis_tuser;
   assign sof        = (x == '0) && (y == '0);
   assign eol        = x == XW'(H_RES - 1);
   assign last_pix   = eol && (y == YW'(V_RES - 1));
   assign check_ok   = (s_prev_axis_tuser == sof) && (s_curr_axis_tuser == sof) &&
                       (s_prev_axis_tlast == eol) && (s_curr_axis_tlast == eol);
   assign fire       = run && both_valid && slot_free && check_ok;
   assign bad        = run && both_valid && !check_ok;
   assign locked     = run;
   // While hunting, non-SOF beats are dropped and SOF beats held; in RUN each side waits on the other
   assign s_prev_axis_tready = aresetn && (run ? slot_free && s_curr_axis_tvalid && check_ok
                                               : s_prev_axis_tvalid && !s_prev_axis_tuser);
   assign s_curr_axis_tready = aresetn && (run ? slot_free && s_prev_axis_tvalid && check_ok
                                               : s_curr_axis_tvalid && !s_curr_axis_tuser);
   // Lock state, raster position and status counters
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= WAIT_SOF;
         x         <= '0;
         y         <= '0;
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (both_sof)
            state <= RUN;
         else if (bad)
            state <= WAIT_SOF;
         if (bad) begin
            x <= '0;
            y <= '0;
         end else if (fire) begin
            x <= eol ? '0 : x + XW'(1);
            if (eol)
               y <= last_pix ? '0 : y + YW'(1);
         end
         if (fire && last_pix)
            frame_cnt <= frame_cnt + 16'd1;
         if (bad && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
      end
   end
   // Output slot: reloads only when empty or being drained, so a stalled pair stays stable
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_axis_tvalid     <= 1'b0;
         m_prev_axis_tdata <= '0;
         m_curr_axis_tdata <= '0;
         m_axis_tuser      <= 1'b0;
         m_axis_tlast      <= 1'b0;
      end else if (slot_free) begin
         m_axis_tvalid <= fire;
         if (fire) begin
            m_prev_axis_tdata <= s_prev_axis_tdata;
            m_curr_axis_tdata <= s_curr_axis_tdata;
            m_axis_tuser      <= sof;
            m_axis_tlast      <= eol;
         end
      end
   end
endmodule

// File: tb/tb_frame_pair_aligner.sv
// tb_frame_pair_aligner: directed stimulus with a queue scoreboard for frame_pair_aligner (3x2 frames)
module tb_frame_pair_aligner;
   typedef struct packed {
      logic        v;
      logic [31:0] d;
      logic        u;
      logic        l;
   } beat_t;
   typedef struct packed {
      logic [31:0] p;
      logic [31:0] c;
      logic        u;
      logic        l;
   } exp_t;
   logic        aclk;
   logic        aresetn;
   logic [31:0] s_prev_axis_tdata;
   logic        s_prev_axis_tvalid;
   logic        s_prev_axis_tready;
   logic        s_prev_axis_tlast;
   logic        s_prev_axis_tuser;
   logic [31:0] s_curr_axis_tdata;
   logic        s_curr_axis_tvalid;
   logic        s_curr_axis_tready;
   logic        s_curr_axis_tlast;
   logic        s_curr_axis_tuser;
   logic [31:0] m_prev_axis_tdata;
   logic [31:0] m_curr_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        locked;
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;
   beat_t       pq[$];
   beat_t       cq[$];
   exp_t        eq[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          cyc = 0;
   logic        tog = 1'b0;
   logic [3:0]  pat = 4'b1001;
   logic        stalled = 1'b0;
   exp_t        held;
   frame_pair_aligner #(.DATA_WIDTH(32), .H_RES(3), .V_RES(2)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_prev_axis_tdata(s_prev_axis_tdata), .s_prev_axis_tvalid(s_prev_axis_tvalid),
      .s_prev_axis_tready(s_prev_axis_tready), .s_prev_axis_tlast(s_prev_axis_tlast),
      .s_prev_axis_tuser(s_prev_axis_tuser),
      .s_curr_axis_tdata(s_curr_axis_tdata), .s_curr_axis_tvalid(s_curr_axis_tvalid),
      .s_curr_axis_tready(s_curr_axis_tready), .s_curr_axis_tlast(s_curr_axis_tlast),
      .s_curr_axis_tuser(s_curr_axis_tuser),
      .m_prev_axis_tdata(m_prev_axis_tdata), .m_curr_axis_tdata(m_curr_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .locked(locked), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   // Scoreboard monitor: pops on every output handshake, checks hold stability and one-sided stalls
   always @(negedge aclk) begin
      if (!aresetn)
         stalled = 1'b0;
      else begin
         if (m_axis_tvalid && stalled)
            check("stable", {m_prev_axis_tdata, m_curr_axis_tdata, m_axis_tuser, m_axis_tlast}, held);
         if (m_axis_tvalid && m_axis_tready) begin
            if (eq.size() == 0) begin
               total_cnt++;
               $display("FAIL extra_beat: got %0h expected none", m_prev_axis_tdata);
            end else
               check("pair", {m_prev_axis_tdata, m_curr_axis_tdata, m_axis_tuser, m_axis_tlast}, eq.pop_front());
         end
         if (locked && s_prev_axis_tvalid && !s_curr_axis_tvalid)
            check("prev_rdy_alone", s_prev_axis_tready, 0);
         if (locked && s_curr_axis_tvalid && !s_prev_axis_tvalid)
            check("curr_rdy_alone", s_curr_axis_tready, 0);
         stalled = m_axis_tvalid && !m_axis_tready;
         held = {m_prev_axis_tdata, m_curr_axis_tdata, m_axis_tuser, m_axis_tlast};
      end
   end
   task automatic drive_heads();
      beat_t p, c;
      p = (pq.size() != 0) ? pq[0] : '0;
      c = (cq.size() != 0) ? cq[0] : '0;
      s_prev_axis_tvalid = p.v;
      s_prev_axis_tdata  = p.v ? p.d : 32'd0;
      s_prev_axis_tuser  = p.v & p.u;
      s_prev_axis_tlast  = p.v & p.l;
      s_curr_axis_tvalid = c.v;
      s_curr_axis_tdata  = c.v ? c.d : 32'd0;
      s_curr_axis_tuser  = c.v & c.u;
      s_curr_axis_tlast  = c.v & c.l;
   endtask
   task automatic cycle();
      logic pr, cr;
      @(negedge aclk);
      pr = s_prev_axis_tready;
      cr = s_curr_axis_tready;
      @(posedge aclk);
      if (pq.size() != 0 && (!pq[0].v || pr)) void'(pq.pop_front());
      if (cq.size() != 0 && (!cq[0].v || cr)) void'(cq.pop_front());
      #1;
      cyc++;
      if (tog) m_axis_tready = pat[cyc % 4];
      drive_heads();
   endtask
   task automatic run_streams();
      int n = 0;
      drive_heads();
      while ((pq.size() != 0 || cq.size() != 0) && n < 500) begin
         cycle();
         n++;
      end
      check("streams_drained", pq.size() + cq.size(), 0);
   endtask
   task automatic drain();
      int n = 0;
      while (eq.size() != 0 && n < 200) begin
         cycle();
         n++;
      end
      check("outputs_drained", eq.size(), 0);
   endtask
   task automatic add_frame(input logic [31:0] bp, input logic [31:0] bc, input int bad,
                            input int gap_at, input int gap_n, input int n);
      for (int i = 0; i < n; i++) begin
         if (i == gap_at)
            for (int g = 0; g < gap_n; g++) pq.push_back('0);
         pq.push_back('{1'b1, bp + 32'(i), i == 0, (i % 3 == 2) || (i == bad)});
         cq.push_back('{1'b1, bc + 32'(i), i == 0, i % 3 == 2});
      end
   endtask
   task automatic exp_frame(input logic [31:0] bp, input logic [31:0] bc, input int n);
      for (int i = 0; i < n; i++) eq.push_back('{bp + 32'(i), bc + 32'(i), i == 0, i % 3 == 2});
   endtask
   task automatic do_reset();
      aresetn = 1'b0;
      m_axis_tready = 1'b1;
      tog = 1'b0;
      pq.delete();
      cq.delete();
      eq.delete();
      drive_heads();
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
   endtask
   initial begin
      do_reset();
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_locked", locked, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_err_cnt", err_cnt, 0);
      // 1: aligned frame, lock follows the joint SOF by one cycle
      add_frame(32'h10, 32'h20, -1, -1, 0, 6);
      exp_frame(32'h10, 32'h20, 6);
      fork
         run_streams();
         begin
            @(posedge aclk);
            #1 check("lock_after_sof", locked, 1);
         end
      join
      drain();
      check("t1_frame_cnt", frame_cnt, 1);
      check("t1_err_cnt", err_cnt, 0);
      check("t1_locked", locked, 1);
      // 2: curr leads with junk, prev SOF must be held
      do_reset();
      for (int k = 0; k < 4; k++) cq.push_back('{1'b1, 32'hDEAD00 + 32'(k), 1'b0, 1'b0});
      add_frame(32'h10, 32'h20, -1, -1, 0, 6);
      exp_frame(32'h10, 32'h20, 6);
      fork
         run_streams();
         repeat (4) begin
            @(negedge aclk);
            check("prev_sof_held", s_prev_axis_tready, 0);
         end
      join
      drain();
      check("t2_frame_cnt", frame_cnt, 1);
      check("t2_err_cnt", err_cnt, 0);
      // 3: downstream backpressure 1,0,0,1
      tog = 1'b1;
      add_frame(32'h10, 32'h20, -1, -1, 0, 6);
      exp_frame(32'h10, 32'h20, 6);
      run_streams();
      drain();
      tog = 1'b0;
      m_axis_tready = 1'b1;
      check("t3_frame_cnt", frame_cnt, 2);
      // 4: early tlast on prev breaks lock, next SOF re-locks
      add_frame(32'h40, 32'h50, 1, -1, 0, 6);
      exp_frame(32'h40, 32'h50, 1);
      add_frame(32'h60, 32'h70, -1, -1, 0, 6);
      exp_frame(32'h60, 32'h70, 6);
      fork
         run_streams();
         begin
            int k = 0;
            while (err_cnt == 0 && k < 100) begin
               @(negedge aclk);
               k++;
            end
            check("lock_drop", locked, 0);
         end
      join
      drain();
      check("t4_err_cnt", err_cnt, 1);
      check("t4_frame_cnt", frame_cnt, 3);
      check("t4_locked", locked, 1);
      // 5: prev gap of 5 cycles mid-frame
      add_frame(32'h80, 32'h90, -1, 2, 5, 6);
      exp_frame(32'h80, 32'h90, 6);
      run_streams();
      drain();
      check("t5_err_cnt", err_cnt, 1);
      check("t5_frame_cnt", frame_cnt, 4);
      // 6: async reset while a pair is held at x=1,y=1
      add_frame(32'hA0, 32'hB0, -1, -1, 0, 4);
      exp_frame(32'hA0, 32'hB0, 4);
      run_streams();
      m_axis_tready = 1'b0;
      @(negedge aclk);
      check("t6_held_valid", m_axis_tvalid, 1);
      check("t6_held_data", m_prev_axis_tdata, 32'hA3);
      #2 aresetn = 1'b0;
      #1;
      check("t6_rst_tvalid", m_axis_tvalid, 0);
      check("t6_rst_locked", locked, 0);
      check("t6_rst_frame_cnt", frame_cnt, 0);
      check("t6_rst_err_cnt", err_cnt, 0);
      eq.delete();
      m_axis_tready = 1'b1;
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      add_frame(32'h10, 32'h20, -1, -1, 0, 6);
      exp_frame(32'h10, 32'h20, 6);
      run_streams();
      drain();
      check("t6_frame_cnt", frame_cnt, 1);
      check("t6_locked", locked, 1);
      repeat (3) @(posedge aclk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
